// File: rtl/uart_port_pkg.sv
// Shared definitions for the UART-to-port bridge: command opcodes, FSM states
// and the command port-range helper.
package uart_port_pkg;

    localparam logic [3:0] OP_WRITE = 4'b0010;
    localparam logic [3:0] OP_READ  = 4'b0011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WDATA   = 3'd1,
        WCOMMIT = 3'd2,
        RREQ    = 3'd3,
        RLATCH  = 3'd4,
        RSEND   = 3'd5,
        RGUARD  = 3'd6
    } state_t;

    // A command port is legal only if every bit above the port width is zero.
    function automatic logic port_fits(input logic [3:0] port, input int addr_bits);
        logic [3:0] high_mask;
        high_mask = 4'hF << addr_bits;
        return (port & high_mask) == 4'h0;
    endfunction

endpackage

// File: rtl/uart_port_ctrl_if.sv
// Byte stream and register-port bus between the UART, the bridge and the ports.
interface uart_port_ctrl_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BITS  = 4
);
    // rx_valid, tx_en, wr_en and rd_en are single-cycle strobes; tx_en is only
    // raised while tx_ready is high, and rd_data is sampled the cycle after rd_en.
    logic                      rx_valid;
    logic [7:0]                rx_data;
    logic                      tx_ready;
    logic                      tx_en;
    logic [7:0]                tx_data;
    logic                      wr_en;
    logic [ADDR_BITS-1:0]      wr_addr;
    logic [8*DATA_BYTES-1:0]   wr_data;
    logic                      rd_en;
    logic [ADDR_BITS-1:0]      rd_addr;
    logic [8*DATA_BYTES-1:0]   rd_data;

    modport master (
        input  rx_valid, rx_data, tx_ready, rd_data,
        output tx_en, tx_data, wr_en, wr_addr, wr_data, rd_en, rd_addr
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, rd_data,
        input  tx_en, tx_data, wr_en, wr_addr, wr_data, rd_en, rd_addr
    );

endinterface

// File: rtl/uart_port_timer.sv
// Inter-byte silence timer: counts enabled cycles since the last clear and
// flags the final cycle of the TIMEOUT_CYCLES window.
module uart_port_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_port_ctrl.sv
// UART command bridge: write/read commands arriving as bytes drive a small
// register-port bus; read words are returned MSB first. Build macro
// UART_PORT_CTRL_TIMEOUT_EN adds an inter-byte timeout while collecting write data.
module uart_port_ctrl
    import uart_port_pkg::*;
#(
    parameter int DATA_BYTES     = 4,
    parameter int ADDR_BITS      = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset_n,
    uart_port_ctrl_if.master port,
    output logic             busy,
    output logic [7:0]       err_count,
    output state_t           state_dbg
);

    localparam int DW = 8 * DATA_BYTES;
    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

    state_t               state, state_nxt;
    logic [1:0]           byte_cnt, byte_cnt_nxt;
    logic [DW-1:0]        shift_r, shift_nxt;
    logic [DW-1:0]        shift_in;
    logic [ADDR_BITS-1:0] addr_r, addr_nxt;
    logic [ADDR_BITS-1:0] wr_addr_r, wr_addr_nxt;
    logic [DW-1:0]        wr_data_r, wr_data_nxt;
    logic                 guard_r, guard_nxt;
    logic [7:0]           err_r;
    logic                 err_inc;
    logic                 cmd_ok;
    logic [3:0]           opcode;
    logic                 timeout;

    assign opcode   = port.rx_data[7:4];
    assign cmd_ok   = ((opcode == OP_WRITE) || (opcode == OP_READ))
                      && port_fits(port.rx_data[3:0], ADDR_BITS);
    assign shift_in = (shift_r << 8) | DW'(port.rx_data);

`ifdef UART_PORT_CTRL_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    assign timer_clear  = (state != WDATA) || port.rx_valid;
    assign timer_enable = (state == WDATA);

    uart_port_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            shift_r   <= '0;
            addr_r    <= '0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            guard_r   <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_cnt  <= byte_cnt_nxt;
            shift_r   <= shift_nxt;
            addr_r    <= addr_nxt;
            wr_addr_r <= wr_addr_nxt;
            wr_data_r <= wr_data_nxt;
            guard_r   <= guard_nxt;
        end
    end

    // Error counter sticks at 255 rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 8'd0;
        end else if (err_inc && (err_r != 8'hFF)) begin
            err_r <= err_r + 8'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        shift_nxt    = shift_r;
        addr_nxt     = addr_r;
        wr_addr_nxt  = wr_addr_r;
        wr_data_nxt  = wr_data_r;
        guard_nxt    = guard_r;
        err_inc      = 1'b0;
        port.tx_en   = 1'b0;
        port.wr_en   = 1'b0;
        port.rd_en   = 1'b0;

        unique case (state)
            IDLE: begin
                if (port.rx_valid) begin
                    if (cmd_ok) begin
                        addr_nxt     = ADDR_BITS'(port.rx_data[3:0]);
                        byte_cnt_nxt = '0;
                        shift_nxt    = '0;
                        state_nxt    = (opcode == OP_WRITE) ? WDATA : RREQ;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end

            WDATA: begin
                if (port.rx_valid) begin
                    shift_nxt    = shift_in;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (byte_cnt == LAST_BYTE) begin
                        // Output registers load now so they are stable for the whole strobe.
                        wr_addr_nxt = addr_r;
                        wr_data_nxt = shift_in;
                        state_nxt   = WCOMMIT;
                    end
                end else if (timeout) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            WCOMMIT: begin
                port.wr_en = 1'b1;
                err_inc    = port.rx_valid;
                state_nxt  = IDLE;
            end

            RREQ: begin
                port.rd_en = 1'b1;
                err_inc    = port.rx_valid;
                state_nxt  = RLATCH;
            end

            RLATCH: begin
                shift_nxt    = port.rd_data;
                byte_cnt_nxt = '0;
                err_inc      = port.rx_valid;
                state_nxt    = RSEND;
            end

            RSEND: begin
                err_inc = port.rx_valid;
                if (port.tx_ready) begin
                    port.tx_en   = 1'b1;
                    shift_nxt    = shift_r << 8;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    guard_nxt    = 1'b0;
                    state_nxt    = (byte_cnt == LAST_BYTE) ? IDLE : RGUARD;
                end
            end

            RGUARD: begin
                // tx_ready may lag the UART accepting a byte; hold off two cycles.
                err_inc = port.rx_valid;
                if (guard_r) begin
                    guard_nxt = 1'b0;
                    state_nxt = RSEND;
                end else begin
                    guard_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign port.tx_data = shift_r[DW-1 -: 8];
    assign port.wr_addr = wr_addr_r;
    assign port.wr_data = wr_data_r;
    assign port.rd_addr = addr_r;
    assign busy         = (state != IDLE);
    assign err_count    = err_r;
    assign state_dbg    = state;

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Directed bench for uart_port_ctrl: a 4-byte/4-bit instance and a 2-byte/3-bit
// instance, with hand-computed expectations and a tx byte scoreboard.
module tb_uart_port_ctrl;
    import uart_port_pkg::*;

    localparam int TO = 20;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_port_ctrl_if #(.DATA_BYTES(4), .ADDR_BITS(4)) bus_a ();
    uart_port_ctrl_if #(.DATA_BYTES(2), .ADDR_BITS(3)) bus_b ();

    logic       busy_a, busy_b;
    logic [7:0] err_a, err_b;
    state_t     st_a, st_b;

    uart_port_ctrl #(.DATA_BYTES(4), .ADDR_BITS(4), .TIMEOUT_CYCLES(TO)) dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .port      (bus_a),
        .busy      (busy_a),
        .err_count (err_a),
        .state_dbg (st_a)
    );

    uart_port_ctrl #(.DATA_BYTES(2), .ADDR_BITS(3), .TIMEOUT_CYCLES(TO)) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .port      (bus_b),
        .busy      (busy_b),
        .err_count (err_b),
        .state_dbg (st_b)
    );

    int          n_checks = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          last_rx_cyc = 0;
    int          wr_cnt_a = 0, rd_cnt_a = 0, tx_cnt_a = 0, wr_cnt_b = 0;
    int          wr_cyc_a = 0, last_tx_cyc = 0;
    logic [3:0]  rd_addr_seen = '0;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_value = '0;
    logic [7:0]  rdy_pat = 8'b1011_0110;
    logic [7:0]  exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Read port: rd_data is valid only the cycle after rd_en, garbage otherwise.
    always @(posedge clock) begin
        #1;
        if (rd_pending) begin
            bus_a.rd_data = rd_value;
            rd_pending    = 1'b0;
        end else begin
            bus_a.rd_data = 32'hDEAD_BEEF;
        end
        bus_a.tx_ready = rdy_pat[cyc[2:0]];
    end

    always @(negedge clock) begin
        if (bus_a.wr_en) begin
            wr_cnt_a++;
            wr_cyc_a = cyc;
        end
        if (bus_a.rd_en) begin
            rd_cnt_a++;
            rd_addr_seen = bus_a.rd_addr;
            rd_pending   = 1'b1;
        end
        if (bus_a.tx_en) begin
            check_val("tx_ready_at_tx_en", 32'(bus_a.tx_ready), 32'd1);
            check_val("tx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_val("tx_byte", 32'(bus_a.tx_data), 32'(exp_q.pop_front()));
            if (tx_cnt_a > 0) check_val("tx_gap_ge3", 32'((cyc - last_tx_cyc) >= 3), 32'd1);
            last_tx_cyc = cyc;
            tx_cnt_a++;
        end
        if (bus_b.wr_en) wr_cnt_b++;
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Called just after a posedge; holds rx_valid for exactly one cycle.
    task automatic send_a(input logic [7:0] b, input int gap);
        bus_a.rx_valid = 1'b1;
        bus_a.rx_data  = b;
        last_rx_cyc    = cyc;
        @(posedge clock);
        #1;
        bus_a.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        bus_b.rx_valid = 1'b1;
        bus_b.rx_data  = b;
        @(posedge clock);
        #1;
        bus_b.rx_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (!busy_a) break;
        end
        check_val("idle_a_reached", 32'(busy_a), 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.rx_valid = 1'b0; bus_a.rx_data = '0;
        bus_b.rx_valid = 1'b0; bus_b.rx_data = '0;
        bus_b.tx_ready = 1'b1; bus_b.rd_data = '0;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_wr_en",   32'(bus_a.wr_en),   32'd0);
        check_val("rst_rd_en",   32'(bus_a.rd_en),   32'd0);
        check_val("rst_tx_en",   32'(bus_a.tx_en),   32'd0);
        check_val("rst_tx_data", 32'(bus_a.tx_data), 32'd0);
        check_val("rst_wr_addr", 32'(bus_a.wr_addr), 32'd0);
        check_val("rst_wr_data", bus_a.wr_data,      32'd0);
        check_val("rst_busy",    32'(busy_a),        32'd0);
        check_val("rst_err",     32'(err_a),         32'd0);
        check_val("rst_state",   32'(st_a),          32'(IDLE));
        reset_n = 1'b1;

        // Write 0x0000000E to port 2, back-to-back bytes
        sync();
        send_a(8'h22, 0); send_a(8'h00, 0); send_a(8'h00, 0); send_a(8'h00, 0); send_a(8'h0E, 0);
        wait_idle_a(20);
        check_val("w1_count",   32'(wr_cnt_a),      32'd1);
        check_val("w1_addr",    32'(bus_a.wr_addr), 32'd2);
        check_val("w1_data",    bus_a.wr_data,      32'h0000_000E);
        check_val("w1_latency", 32'(wr_cyc_a),      32'(last_rx_cyc + 1));
        check_val("w1_err",     32'(err_a),         32'd0);

        // Write 0xFFFFFFB1 to port 3, uneven gaps
        sync();
        send_a(8'h23, 1); send_a(8'hFF, 2); send_a(8'hFF, 1); send_a(8'hFF, 0); send_a(8'hB1, 0);
        wait_idle_a(20);
        check_val("w2_count",   32'(wr_cnt_a),      32'd2);
        check_val("w2_addr",    32'(bus_a.wr_addr), 32'd3);
        check_val("w2_data",    bus_a.wr_data,      32'hFFFF_FFB1);
        check_val("w2_latency", 32'(wr_cyc_a),      32'(last_rx_cyc + 1));

        // Read port 1 returning 0x00003162
        rd_value = 32'h0000_3162;
        push_word(rd_value);
        sync();
        send_a(8'h31, 0);
        wait_idle_a(200);
        check_val("r1_rd_count", 32'(rd_cnt_a),     32'd1);
        check_val("r1_rd_addr",  32'(rd_addr_seen), 32'd1);
        check_val("r1_tx_count", 32'(tx_cnt_a),     32'd4);
        check_val("r1_q_empty",  32'(exp_q.size()), 32'd0);
        check_val("r1_err",      32'(err_a),        32'd0);
        check_val("r1_wr_hold",  bus_a.wr_data,     32'hFFFF_FFB1);

        // Bad opcode, then a normal write
        sync();
        send_a(8'h45, 2);
        @(negedge clock);
        check_val("bad_err",   32'(err_a),    32'd1);
        check_val("bad_busy",  32'(busy_a),   32'd0);
        check_val("bad_no_wr", 32'(wr_cnt_a), 32'd2);
        check_val("bad_no_rd", 32'(rd_cnt_a), 32'd1);
        sync();
        send_a(8'h22, 0); send_a(8'h12, 0); send_a(8'h34, 0); send_a(8'h56, 0); send_a(8'h78, 0);
        wait_idle_a(20);
        check_val("w3_count", 32'(wr_cnt_a),      32'd3);
        check_val("w3_addr",  32'(bus_a.wr_addr), 32'd2);
        check_val("w3_data",  bus_a.wr_data,      32'h1234_5678);

        // Read port 3 with a stray byte arriving mid-read
        rd_value = 32'hA5C3_0F81;
        push_word(rd_value);
        sync();
        send_a(8'h33, 3);
        send_a(8'h99, 0);
        wait_idle_a(200);
        check_val("r2_rd_count", 32'(rd_cnt_a),     32'd2);
        check_val("r2_rd_addr",  32'(rd_addr_seen), 32'd3);
        check_val("r2_tx_count", 32'(tx_cnt_a),     32'd8);
        check_val("r2_q_empty",  32'(exp_q.size()), 32'd0);
        check_val("r2_err",      32'(err_a),        32'd2);

        // Narrow instance: 2 data bytes, 3 address bits
        sync();
        send_b(8'h25); send_b(8'h12); send_b(8'h34);
        @(negedge clock);
        @(negedge clock);
        check_val("b_wr_count", 32'(wr_cnt_b),      32'd1);
        check_val("b_wr_addr",  32'(bus_b.wr_addr), 32'd5);
        check_val("b_wr_data",  32'(bus_b.wr_data), 32'h1234);
        check_val("b_err0",     32'(err_b),         32'd0);
        sync();
        send_b(8'h28);
        @(negedge clock);
        check_val("b_err1",      32'(err_b),    32'd1);
        check_val("b_no_wr",     32'(wr_cnt_b), 32'd1);
        check_val("b_busy_idle", 32'(busy_b),   32'd0);

        // Saturation: 260 bad bytes on top of 2 errors
        sync();
        for (int i = 0; i < 260; i++) send_a(8'h45, 0);
        @(negedge clock);
        check_val("err_saturate", 32'(err_a), 32'd255);

        // Reset in the middle of a write
        sync();
        send_a(8'h22, 0); send_a(8'h00, 0); send_a(8'h00, 0);
        reset_n = 1'b0;
        @(negedge clock);
        check_val("mid_rst_busy", 32'(busy_a),   32'd0);
        check_val("mid_rst_err",  32'(err_a),    32'd0);
        check_val("mid_rst_data", bus_a.wr_data, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check_val("mid_rst_no_wr", 32'(wr_cnt_a), 32'd3);
        sync();
        send_a(8'h21, 0); send_a(8'h00, 0); send_a(8'h00, 0); send_a(8'h00, 0); send_a(8'h07, 0);
        wait_idle_a(20);
        check_val("w4_count", 32'(wr_cnt_a),      32'd4);
        check_val("w4_addr",  32'(bus_a.wr_addr), 32'd1);
        check_val("w4_data",  bus_a.wr_data,      32'h0000_0007);
        check_val("w4_err",   32'(err_a),         32'd0);

`ifdef UART_PORT_CTRL_TIMEOUT_EN
        // Silence after two data bytes aborts the write
        sync();
        send_a(8'h22, 0); send_a(8'h00, 0); send_a(8'h00, 0);
        repeat (TO + 1) @(posedge clock);
        @(negedge clock);
        check_val("to_no_wr", 32'(wr_cnt_a), 32'd4);
        check_val("to_err",   32'(err_a),    32'd1);
        check_val("to_busy",  32'(busy_a),   32'd0);
        sync();
        send_a(8'h24, 0); send_a(8'hCA, 0); send_a(8'hFE, 0); send_a(8'hBA, 0); send_a(8'hBE, 0);
        wait_idle_a(20);
        check_val("to_w_count", 32'(wr_cnt_a),      32'd5);
        check_val("to_w_addr",  32'(bus_a.wr_addr), 32'd4);
        check_val("to_w_data",  bus_a.wr_data,      32'hCAFE_BABE);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_port_ctrl.md
UART_PORT_CTRL -- requirements
Module: uart_port_ctrl

Interface
REQ-001 Parameter DATA_BYTES, default 4, port word width in bytes (1..4).
REQ-002 Parameter ADDR_BITS, default 4, port address width (1..4).
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clock cycles (1 ms at 100 MHz).
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clock  in  1  master clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 rx_valid  in  1  one-cycle pulse: UART received byte on rx_data.
REQ-008 rx_data  in  8  received byte.
REQ-009 tx_ready  in  1  level: UART can accept a byte.
REQ-010 tx_en  out  1  one-cycle pulse: load tx_data into UART.
REQ-011 tx_data  out  8  byte to transmit.
REQ-012 wr_en  out  1  one-cycle port write strobe.
REQ-013 wr_addr  out  ADDR_BITS  write port address.
REQ-014 wr_data  out  8*DATA_BYTES  write word.
REQ-015 rd_en  out  1  one-cycle port read strobe.
REQ-016 rd_addr  out  ADDR_BITS  read port address.
REQ-017 rd_data  in  8*DATA_BYTES  read word, valid the cycle after rd_en.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 err_count  out  8  saturating error counter.

Function
REQ-020 Command byte: bits[7:4] opcode (4'b0010 write, 4'b0011 read), bits[3:0] port; port bits above ADDR_BITS SHALL be zero.
REQ-021 States: IDLE, WDATA, WCOMMIT, RREQ, RLATCH, RSEND, RGUARD; IDLE accepts only command bytes.
REQ-022 Invalid opcode or nonzero high port bits in IDLE: byte discarded, err_count +1, stay IDLE, no strobe.
REQ-023 Write: IDLE->WDATA; exactly DATA_BYTES following bytes collected MSB first; cycle after last rx_valid enter WCOMMIT, wr_en=1 for one cycle with wr_addr/wr_data stable, then IDLE.
REQ-024 wr_addr/wr_data SHALL hold last committed values between strobes.
REQ-025 Read: IDLE->RREQ; rd_en=1 one cycle with rd_addr; RLATCH captures rd_data next cycle; then RSEND.
REQ-026 RSEND: when tx_ready=1 drive tx_en=1 one cycle with next byte MSB first, go RGUARD; RGUARD ignores tx_ready 2 cycles then returns RSEND; after byte DATA_BYTES, return IDLE.
REQ-027 rx_valid during RREQ/RLATCH/RSEND/RGUARD: byte discarded, err_count +1, read completes unaffected.
REQ-028 err_count SHALL saturate at 255; increments never wrap.
REQ-029 Total write latency: wr_en asserted exactly 1 cycle after the last data rx_valid.

Reset
REQ-030 On reset_n=0 all outputs SHALL be 0, state IDLE, err_count 0, shift registers 0.
REQ-031 Reset mid-command SHALL discard partial data with no strobe; a tx_en already issued is not retracted.

Configuration
REQ-032 Macro UART_PORT_CTRL_TIMEOUT_EN defined: in WDATA, TIMEOUT_CYCLES cycles without rx_valid since the previous byte aborts to IDLE, err_count +1, no wr_en.
REQ-033 Macro undefined: WDATA waits indefinitely; timer logic absent; TIMEOUT_CYCLES unused.

Structure
REQ-034 Package uart_port_pkg SHALL hold opcode constants OP_WRITE=4'b0010, OP_READ=4'b0011 and the state enumeration.
REQ-035 Timeout counter SHALL be sub-module uart_port_timer (clear, enable, expired), instantiated only under UART_PORT_CTRL_TIMEOUT_EN.

Verification
REQ-036 Bytes 0x22,00,00,00,0E -> one wr_en, wr_addr=2, wr_data=0x0000000E, err_count=0.
REQ-037 Bytes 0x23,FF,FF,FF,B1 (-79) -> one wr_en, wr_addr=3, wr_data=0xFFFFFFB1.
REQ-038 Byte 0x31, rd_data=0x00003162 -> rd_en once with rd_addr=1; tx bytes 00,00,31,62 in order, each tx_en only while tx_ready=1.
REQ-039 Byte 0x45 -> no strobes, err_count=1; following 0x22 write completes normally.
REQ-040 With UART_PORT_CTRL_TIMEOUT_EN: 0x22,00,00 then silence TIMEOUT_CYCLES+1 cycles -> no wr_en, err_count=1, busy=0; next full write succeeds.
REQ-041 DATA_BYTES=2, ADDR_BITS=3: bytes 0x25,12,34 -> wr_addr=5, wr_data=0x1234; byte 0x28 -> err_count +1.
